// File: rtl/flash_cmd_arbiter.sv
// rtl/flash_cmd_arbiter.sv - round-robin arbiter and start/ready sequencer for one NOR flash command controller
// Define FLASH_ARB_WDOG_EN to add the ISSUE-state ack watchdog that drives oERR.
module flash_cmd_arbiter #(
  parameter int N_REQ      = 3,
  parameter int GAP_CYCLES = 4,
  parameter int ACK_TO     = 64
) (
  input  logic                 iCLK,
  input  logic                 iRST_n,
  input  logic [N_REQ-1:0]     iREQ,
  input  logic [3*N_REQ-1:0]   iCMD,
  input  logic [20*N_REQ-1:0]  iADDR,
  input  logic [8*N_REQ-1:0]   iWDATA,
  output logic [N_REQ-1:0]     oGNT,
  output logic [N_REQ-1:0]     oDONE,
  output logic [N_REQ-1:0]     oERR,
  output logic [7:0]           oRDATA,
  output logic                 oBUSY,
  output logic [2:0]           oFL_CMD,
  output logic [19:0]          oFL_ADDR,
  output logic [7:0]           oFL_DATA,
  output logic                 oFL_Start,
  input  logic [7:0]           iFL_DATA,
  input  logic                 iFL_Ready
);
  localparam int PW = $clog2(N_REQ);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [2:0]    CMD_READ = 3'h1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_GAP} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, win, cand;
  logic [GW-1:0]   gap_cnt;
  logic            take, finish, timeout;
  logic [2:0]      cmd_a   [N_REQ];
  logic [19:0]     addr_a  [N_REQ];
  logic [7:0]      wdata_a [N_REQ];

`ifdef FLASH_ARB_WDOG_EN
  localparam logic [7:0] WD_LAST = 8'(ACK_TO - 1);
  logic [7:0] wd_cnt;
`endif

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      cmd_a[k]   = iCMD[3*k +: 3];
      addr_a[k]  = iADDR[20*k +: 20];
      wdata_a[k] = iWDATA[8*k +: 8];
    end
  end

  // Scan downward so the last hit is the first requester above the pointer.
  always_comb begin
    win  = ptr;
    cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = PW'((int'(ptr) + k) % N_REQ);
      if (iREQ[cand]) win = cand;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) state <= S_GAP;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    take    = 1'b0;
    finish  = 1'b0;
    timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (|iREQ) begin
          state_n = S_ISSUE;
          take    = 1'b1;
        end
      end
      S_ISSUE: begin
        // Only a low ready counts as ack; a stale high ready is ignored here.
        if (!iFL_Ready) state_n = S_BUSY;
`ifdef FLASH_ARB_WDOG_EN
        else if (wd_cnt == WD_LAST) begin
          state_n = S_GAP;
          timeout = 1'b1;
        end
`endif
      end
      S_BUSY: begin
        if (iFL_Ready) begin
          state_n = S_GAP;
          finish  = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_n = S_IDLE;
      end
      default: state_n = S_GAP;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      gap_cnt   <= '0;
      ptr       <= PW'(N_REQ - 1);
      oGNT      <= '0;
      oDONE     <= '0;
      oRDATA    <= '0;
      oFL_CMD   <= '0;
      oFL_ADDR  <= '0;
      oFL_DATA  <= '0;
      oFL_Start <= 1'b0;
    end else begin
      oDONE     <= '0;
      oFL_Start <= (state_n == S_ISSUE);
      gap_cnt   <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;
      if (take) begin
        oGNT     <= N_REQ'(1) << win;
        ptr      <= win;
        oFL_CMD  <= cmd_a[win];
        oFL_ADDR <= addr_a[win];
        oFL_DATA <= wdata_a[win];
      end
      if (finish) begin
        oDONE <= oGNT;
        oGNT  <= '0;
        if (oFL_CMD == CMD_READ) oRDATA <= iFL_DATA;
      end
      if (timeout) oGNT <= '0;
    end
  end

`ifdef FLASH_ARB_WDOG_EN
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      wd_cnt <= '0;
      oERR   <= '0;
    end else begin
      wd_cnt <= (state == S_ISSUE) ? wd_cnt + 8'd1 : 8'd0;
      oERR   <= timeout ? oGNT : '0;
    end
  end
`else
  assign oERR = '0;
`endif

  assign oBUSY = (state != S_IDLE);

endmodule

// File: tb/tb_flash_cmd_arbiter.sv
// tb/tb_flash_cmd_arbiter.sv - randomized self-checking bench for flash_cmd_arbiter
module tb_flash_cmd_arbiter;
  localparam int N = 3, G = 4, ACK_TO = 64;
  localparam logic [2:0] RD = 3'h1, WR = 3'h2;

  logic            iCLK = 1'b0, iRST_n = 1'b0;
  logic [N-1:0]    iREQ = '0;
  logic [3*N-1:0]  iCMD = '0;
  logic [20*N-1:0] iADDR = '0;
  logic [8*N-1:0]  iWDATA = '0;
  logic [N-1:0]    oGNT, oDONE, oERR;
  logic [7:0]      oRDATA, oFL_DATA;
  logic [7:0]      iFL_DATA = '0;
  logic            oBUSY, oFL_Start;
  logic [2:0]      oFL_CMD;
  logic [19:0]     oFL_ADDR;
  logic            iFL_Ready = 1'b0;

  flash_cmd_arbiter #(.N_REQ(N), .GAP_CYCLES(G), .ACK_TO(ACK_TO)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iREQ(iREQ), .iCMD(iCMD), .iADDR(iADDR),
    .iWDATA(iWDATA), .oGNT(oGNT), .oDONE(oDONE), .oERR(oERR), .oRDATA(oRDATA),
    .oBUSY(oBUSY), .oFL_CMD(oFL_CMD), .oFL_ADDR(oFL_ADDR), .oFL_DATA(oFL_DATA),
    .oFL_Start(oFL_Start), .iFL_DATA(iFL_DATA), .iFL_Ready(iFL_Ready)
  );

  always #5 iCLK = ~iCLK;

  int total = 0, bad = 0, cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model state: transaction-level view of the arbiter.
  int          anchor = 0, m_ptr = N - 1, m_win = 0, to_iter = -1;
  bit          active = 0, exp_start = 0, ev_ack = 0, ev_done = 0;
  logic [2:0]  m_cmd = '0;
  logic [19:0] m_addr = '0;
  logic [7:0]  m_wdata = '0, exp_rdata = '0, done_data = '0;
  int          gq[$];
  int          done_cnt = 0, err_cnt = 0, low_run = 0, start_iter = -1;
  bit          last_start = 0;
  // Flash controller model.
  int          fl_phase = 0, fl_cnt = 0, fix_ack = -1, fix_busy = -1, fix_data = -1;
  bit          no_ack = 0;

  function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 1; k <= N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic model_and_check();
    logic [N-1:0] oh, dexp, eexp;
    oh = '0; dexp = '0; eexp = '0;
    if (!iRST_n) begin
      active = 0; exp_start = 0; ev_ack = 0; ev_done = 0; to_iter = -1;
      m_ptr = N - 1; exp_rdata = '0; anchor = cyc; fl_phase = 0; iFL_Ready = 1'b1;
      check_eq("rst_gnt", 32'(oGNT), 0);
      check_eq("rst_done", 32'(oDONE), 0);
      check_eq("rst_err", 32'(oERR), 0);
      check_eq("rst_rdata", 32'(oRDATA), 0);
      check_eq("rst_flcmd", {oFL_CMD, oFL_DATA, oFL_ADDR}, 0);
      check_eq("rst_start", 32'(oFL_Start), 0);
    end else begin
      if (ev_ack) begin exp_start = 0; ev_ack = 0; end
      if (ev_done) begin
        dexp[m_win] = 1'b1;
        if (m_cmd == RD) exp_rdata = done_data;
        active = 0; anchor = cyc; ev_done = 0; done_cnt++;
      end
      if (to_iter == cyc) begin
        eexp[m_win] = 1'b1;
        active = 0; exp_start = 0; anchor = cyc; fl_phase = 0; to_iter = -1; err_cnt++;
      end
      if (!active && cyc - 1 >= anchor + G && iREQ != '0) begin
        m_win   = rr_pick(iREQ, m_ptr);
        m_ptr   = m_win;
        m_cmd   = iCMD[3*m_win +: 3];
        m_addr  = iADDR[20*m_win +: 20];
        m_wdata = iWDATA[8*m_win +: 8];
        active = 1; exp_start = 1;
        gq.push_back(m_win);
        fl_phase = 1;
        fl_cnt = (fix_ack >= 0) ? fix_ack : $urandom_range(0, 7);
        if (no_ack) to_iter = cyc + ACK_TO;
      end
      if (active) oh[m_win] = 1'b1;
      check_eq("gnt", 32'(oGNT), 32'(oh));
      check_eq("done", 32'(oDONE), 32'(dexp));
      check_eq("err", 32'(oERR), 32'(eexp));
      check_eq("start", 32'(oFL_Start), 32'(exp_start));
      check_eq("rdata", 32'(oRDATA), 32'(exp_rdata));
      check_eq("busy", 32'(oBUSY), 32'(!(!active && cyc >= anchor + G)));
      if (active) begin
        check_eq("fl_cmd", 32'(oFL_CMD), 32'(m_cmd));
        check_eq("fl_addr", 32'(oFL_ADDR), 32'(m_addr));
        check_eq("fl_data", 32'(oFL_DATA), 32'(m_wdata));
      end
      if (oFL_Start && !last_start) begin
        check_eq("start_gap", 32'(low_run >= G), 1);
        start_iter = cyc;
      end
    end
    low_run    = oFL_Start ? 0 : low_run + 1;
    last_start = oFL_Start;
  endtask

  task automatic flash_drive();
    iFL_DATA = 8'($urandom());
    case (fl_phase)
      1: if (!no_ack) begin
        if (fl_cnt == 0) begin
          iFL_Ready = 1'b0; ev_ack = 1; fl_phase = 2;
          fl_cnt = (fix_busy >= 0) ? fix_busy : $urandom_range(0, 10);
        end else fl_cnt--;
      end
      2: begin
        if (fl_cnt == 0) begin
          done_data = (fix_data >= 0) ? 8'(fix_data) : 8'($urandom());
          iFL_DATA = done_data; iFL_Ready = 1'b1; ev_done = 1; fl_phase = 0;
        end else fl_cnt--;
      end
      default: ;
    endcase
  endtask

  task automatic step();
    @(negedge iCLK);
    cyc++;
    model_and_check();
    flash_drive();
  endtask

  task automatic wait_done(input int n, input int budget);
    int target;
    target = done_cnt + n;
    for (int k = 0; k < budget && done_cnt < target; k++) step();
    check_eq("done_budget", 32'(done_cnt >= target), 1);
  endtask

  task automatic rand_fields();
    iCMD   = 9'($urandom());
    iADDR  = 60'({$urandom(), $urandom()});
    iWDATA = 24'($urandom());
    for (int k = 0; k < N; k++) if ($urandom_range(0, 1) == 1) iCMD[3*k +: 3] = RD;
  endtask

  initial begin
    int rel, guard;
    // Write from requester 1 straight out of reset.
    iREQ = 3'b010; iCMD[5:3] = WR; iADDR[39:20] = 20'h00040; iWDATA[15:8] = 8'hC3;
    fix_ack = 2; fix_busy = 3;
    repeat (3) step();
    iRST_n = 1'b1; rel = cyc;
    wait_done(1, 100);
    iREQ = '0;
    check_eq("wr_start_lat", 32'(start_iter - rel), G + 1);
    check_eq("wr_rdata", 32'(oRDATA), 0);

    // Single read with a long stale-ready window.
    iREQ = 3'b001; iCMD[2:0] = RD; iADDR[19:0] = 20'h00123;
    fix_ack = 10; fix_busy = 20; fix_data = 8'h5A;
    wait_done(1, 200);
    iREQ = '0;
    check_eq("rd_rdata", 32'(oRDATA), 32'h5A);

    // Round robin with all requesters held.
    iRST_n = 1'b0; step(); step(); iRST_n = 1'b1;
    gq.delete(); fix_ack = -1; fix_busy = -1; fix_data = -1;
    iREQ = 3'b111;
    wait_done(6, 400);
    iREQ = '0;
    for (int k = 0; k < 6; k++)
      check_eq("rr_order", (k < gq.size()) ? 32'(gq[k]) : 32'hFFFF_FFFF, 32'(k % 3));

    // Reset during BUSY, then normal service.
    iREQ = 3'b100; fix_busy = 8;
    guard = 0;
    while (fl_phase != 2 && guard < 100) begin step(); guard++; end
    check_eq("reach_busy", 32'(fl_phase == 2), 1);
    step();
    iRST_n = 1'b0; step(); iRST_n = 1'b1;
    fix_busy = -1;
    wait_done(1, 200);
    iREQ = '0;

`ifdef FLASH_ARB_WDOG_EN
    // Controller never acks: expect an error pulse, then the next requester.
    iREQ = 3'b011; no_ack = 1; guard = 0;
    begin
      int e0;
      e0 = err_cnt;
      while (err_cnt == e0 && guard < 300) begin step(); guard++; end
      check_eq("wd_err_seen", 32'(err_cnt > e0), 1);
    end
    no_ack = 0;
    wait_done(1, 200);
    iREQ = '0;
    check_eq("wd_next_req", 32'(gq[gq.size()-1] != gq[gq.size()-2]), 1);
`endif

    // Random traffic with requester fields changing every cycle.
    for (int i = 0; i < 600; i++) begin
      iREQ = N'($urandom());
      rand_fields();
      step();
    end
    iREQ = '0;
    guard = 0;
    while (active && guard < 200) begin step(); guard++; end
    check_eq("drain", 32'(active), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end
endmodule
